// File: rtl/up_down_direction_decoder_pkg.sv
// Shared types for the up/down direction decoder: FSM states, delta classes
// and the default lock threshold.
package up_down_direction_decoder_pkg;

  typedef enum logic [1:0] {
    ST_INIT      = 2'd0,
    ST_SEEK      = 2'd1,
    ST_LOCK_UP   = 2'd2,
    ST_LOCK_DOWN = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    DC_UP      = 2'd0,
    DC_DOWN    = 2'd1,
    DC_HOLD    = 2'd2,
    DC_ILLEGAL = 2'd3
  } delta_class_t;

  localparam int DEFAULT_LOCK_CNT = 3;
  localparam int RUN_W            = 4;
  localparam int ERR_CNT_W        = 8;

  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (v == {ERR_CNT_W{1'b1}}) ? v : v + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/up_down_direction_decoder_delta_classifier.sv
// Combinational classification of (count_in - prev) mod 2^WIDTH into
// up / down / hold / illegal.
module delta_classifier
  import up_down_direction_decoder_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] prev,
  input  logic [WIDTH-1:0] count_in,
  output delta_class_t     delta_class
);

  logic [WIDTH-1:0] delta;
  logic [WIDTH-1:0] one;

  assign delta = count_in - prev;
  assign one   = {{(WIDTH-1){1'b0}}, 1'b1};

  // +1 is checked before all-ones so a 1-bit bus still resolves to a single class
  always_comb begin
    delta_class = DC_ILLEGAL;
    if (delta == '0) begin
      delta_class = DC_HOLD;
    end else if (delta == one) begin
      delta_class = DC_UP;
    end else if (delta == '1) begin
      delta_class = DC_DOWN;
    end
  end

endmodule

// File: rtl/up_down_direction_decoder.sv
// Tracks an observed up/down counter, reports step/hold/error pulses, the
// last direction, and locks after LOCK_CNT consecutive same-direction steps.
module up_down_direction_decoder
  import up_down_direction_decoder_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int LOCK_CNT = DEFAULT_LOCK_CNT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     count_in,
  input  logic                 sample_en,
  output logic                 dir,
  output logic                 step,
  output logic                 hold,
  output logic                 err,
  output logic                 locked,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam logic [RUN_W-1:0] LOCK_RUN = RUN_W'(LOCK_CNT);
  localparam logic [RUN_W-1:0] RUN_ONE  = RUN_W'(1);

  state_t                 state_reg, state_next;
  logic [RUN_W-1:0]       run_reg, run_next;
  logic [WIDTH-1:0]       prev_reg, prev_next;
  logic                   dir_reg, dir_next;
  logic                   step_reg, step_next;
  logic                   hold_reg, hold_next;
  logic                   err_reg, err_next;
  logic                   locked_reg, locked_next;
  logic [ERR_CNT_W-1:0]   err_count_reg, err_count_next;

  delta_class_t           delta_class;
  logic                   is_up;
  logic [RUN_W-1:0]       run_seek;

  delta_classifier #(
    .WIDTH(WIDTH)
  ) u_classifier (
    .prev       (prev_reg),
    .count_in   (count_in),
    .delta_class(delta_class)
  );

  assign is_up    = (delta_class == DC_UP);
  // A step in the remembered direction extends the run; otherwise it restarts at 1
  assign run_seek = (is_up == dir_reg) ? run_reg + RUN_ONE : RUN_ONE;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_INIT;
      run_reg       <= '0;
      prev_reg      <= '0;
      dir_reg       <= 1'b1;
      step_reg      <= 1'b0;
      hold_reg      <= 1'b0;
      err_reg       <= 1'b0;
      locked_reg    <= 1'b0;
      err_count_reg <= '0;
    end else begin
      state_reg     <= state_next;
      run_reg       <= run_next;
      prev_reg      <= prev_next;
      dir_reg       <= dir_next;
      step_reg      <= step_next;
      hold_reg      <= hold_next;
      err_reg       <= err_next;
      locked_reg    <= locked_next;
      err_count_reg <= err_count_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    run_next       = run_reg;
    prev_next      = prev_reg;
    dir_next       = dir_reg;
    step_next      = 1'b0;
    hold_next      = 1'b0;
    err_next       = 1'b0;
    err_count_next = err_count_reg;

    if (sample_en) begin
      prev_next = count_in;
      if (state_reg == ST_INIT) begin
        state_next = ST_SEEK;
        run_next   = '0;
      end else begin
        unique case (delta_class)
          DC_HOLD: begin
            hold_next = 1'b1;
          end
          DC_ILLEGAL: begin
            err_next       = 1'b1;
            state_next     = ST_SEEK;
            run_next       = '0;
            err_count_next = sat_inc(err_count_reg);
          end
          default: begin
            step_next = 1'b1;
            dir_next  = is_up;
            if (state_reg == ST_SEEK) begin
              if (run_seek >= LOCK_RUN) begin
                state_next = is_up ? ST_LOCK_UP : ST_LOCK_DOWN;
                run_next   = LOCK_RUN;
              end else begin
                run_next = run_seek;
              end
            end else if (is_up == dir_reg) begin
              run_next = LOCK_RUN;
            end else begin
              // Reversal out of lock: a threshold of 1 re-locks immediately
              run_next = RUN_ONE;
              if (LOCK_RUN == RUN_ONE) begin
                state_next = is_up ? ST_LOCK_UP : ST_LOCK_DOWN;
              end else begin
                state_next = ST_SEEK;
              end
            end
          end
        endcase
      end
    end

    locked_next = (state_next == ST_LOCK_UP) || (state_next == ST_LOCK_DOWN);
  end

  assign dir       = dir_reg;
  assign step      = step_reg;
  assign hold      = hold_reg;
  assign err       = err_reg;
  assign locked    = locked_reg;
  assign err_count = err_count_reg;

endmodule

// File: tb/tb_up_down_direction_decoder.sv
// Directed-vector scoreboard bench for up_down_direction_decoder: stimulus
// pushes hand-computed responses, a monitor pops and compares each cycle.
module tb_up_down_direction_decoder;

  typedef struct packed {
    logic       step;
    logic       hold;
    logic       err;
    logic       dir;
    logic       locked;
    logic [7:0] ec;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [3:0] count_in;
  logic       sample_en;
  logic       dir;
  logic       step;
  logic       hold;
  logic       err;
  logic       locked;
  logic [7:0] err_count;

  exp_t exp_q[$];
  int   n_vec;
  int   n_bad;

  up_down_direction_decoder #(
    .WIDTH   (4),
    .LOCK_CNT(3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .count_in (count_in),
    .sample_en(sample_en),
    .dir      (dir),
    .step     (step),
    .hold     (hold),
    .err      (err),
    .locked   (locked),
    .err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t got_now();
    exp_t g;
    g.step   = step;
    g.hold   = hold;
    g.err    = err;
    g.dir    = dir;
    g.locked = locked;
    g.ec     = err_count;
    return g;
  endfunction

  task automatic compare(input string name, input exp_t want);
    exp_t got;
    got = got_now();
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got step=%b hold=%b err=%b dir=%b locked=%b err_count=%0d, want step=%b hold=%b err=%b dir=%b locked=%b err_count=%0d",
               name, got.step, got.hold, got.err, got.dir, got.locked, got.ec,
               want.step, want.hold, want.err, want.dir, want.locked, want.ec);
    end else begin
      $display("ok   %s: step=%b hold=%b err=%b dir=%b locked=%b err_count=%0d",
               name, got.step, got.hold, got.err, got.dir, got.locked, got.ec);
    end
  endtask

  // Monitor: the DUT presents a response one edge after every driven cycle
  initial begin
    exp_t want;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        want = exp_q.pop_front();
        compare($sformatf("vec%0d", n_vec), want);
      end
    end
  end

  task automatic apply(input logic en, input logic [3:0] c,
                       input logic s, input logic h, input logic e,
                       input logic d, input logic l, input logic [7:0] ec);
    exp_t x;
    @(negedge clk);
    sample_en = en;
    count_in  = c;
    x.step = s; x.hold = h; x.err = e; x.dir = d; x.locked = l; x.ec = ec;
    exp_q.push_back(x);
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while (exp_q.size() > 0 && budget < 50) begin
      @(posedge clk);
      budget++;
    end
    #2;
    if (exp_q.size() > 0) begin
      n_bad++;
      $display("FAIL drain: %0d responses still pending, want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Asserts reset mid-cycle; outputs must clear at once, without a clock edge
  task automatic pulse_reset(input string name);
    exp_t r;
    drain();
    @(negedge clk);
    sample_en = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    r = '0;
    r.dir = 1'b1;
    compare({name, "_async"}, r);
    @(negedge clk);
    #1;
    compare({name, "_held"}, r);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    exp_t r;
    n_vec     = 0;
    n_bad     = 0;
    rst       = 1'b1;
    sample_en = 1'b0;
    count_in  = 4'd0;
    repeat (2) @(negedge clk);
    #1;
    r = '0;
    r.dir = 1'b1;
    compare("por", r);
    @(negedge clk);
    rst = 1'b0;

    // Up run 5,6,7,8 then lock; stay locked, hold, illegal
    //    en  cnt   step hold err dir lock ec
    apply(1, 4'd5,  0, 0, 0, 1, 0, 8'd0);
    apply(1, 4'd6,  1, 0, 0, 1, 0, 8'd0);
    apply(1, 4'd7,  1, 0, 0, 1, 0, 8'd0);
    apply(1, 4'd8,  1, 0, 0, 1, 1, 8'd0);
    apply(1, 4'd9,  1, 0, 0, 1, 1, 8'd0);
    apply(1, 4'd9,  0, 1, 0, 1, 1, 8'd0);
    apply(1, 4'd12, 0, 0, 1, 1, 0, 8'd1);

    // sample_en gaps between samples 3 and 4
    apply(1, 4'd2,  0, 0, 1, 1, 0, 8'd2);
    apply(1, 4'd3,  1, 0, 0, 1, 0, 8'd2);
    apply(0, 4'd9,  0, 0, 0, 1, 0, 8'd2);
    apply(0, 4'd0,  0, 0, 0, 1, 0, 8'd2);
    apply(0, 4'd7,  0, 0, 0, 1, 0, 8'd2);
    apply(1, 4'd4,  1, 0, 0, 1, 0, 8'd2);
    apply(1, 4'd5,  1, 0, 0, 1, 1, 8'd2);

    // Up wrap 14,15,0,1 then reverse through 0 -> 15 and lock down
    pulse_reset("rst1");
    apply(1, 4'd14, 0, 0, 0, 1, 0, 8'd0);
    apply(1, 4'd15, 1, 0, 0, 1, 0, 8'd0);
    apply(1, 4'd0,  1, 0, 0, 1, 0, 8'd0);
    apply(1, 4'd1,  1, 0, 0, 1, 1, 8'd0);
    apply(1, 4'd1,  0, 1, 0, 1, 1, 8'd0);
    apply(1, 4'd0,  1, 0, 0, 0, 0, 8'd0);
    apply(1, 4'd15, 1, 0, 0, 0, 0, 8'd0);
    apply(1, 4'd14, 1, 0, 0, 0, 1, 8'd0);
    apply(1, 4'd13, 1, 0, 0, 0, 1, 8'd0);

    // Reset while in LOCK_DOWN; first sample after release is an INIT sample
    pulse_reset("rst_lockdown");
    apply(1, 4'd7,  0, 0, 0, 1, 0, 8'd0);
    apply(1, 4'd6,  1, 0, 0, 0, 0, 8'd0);

    // 256 illegal jumps 0/8: err_count saturates at 255
    for (int k = 1; k <= 256; k++) begin
      apply(1, (k % 2 == 1) ? 4'd0 : 4'd8, 0, 0, 1, 0, 0,
            (k >= 255) ? 8'd255 : 8'(k));
    end
    apply(1, 4'd9,  1, 0, 0, 1, 0, 8'd255);
    apply(1, 4'd9,  0, 1, 0, 1, 0, 8'd255);

    drain();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/up_down_direction_decoder.md
UP_DOWN_DIRECTION_DECODER -- requirements
Module: up_down_direction_decoder

Interface
REQ-001 Parameter WIDTH, default 4: width of the observed count bus.
REQ-002 Parameter LOCK_CNT, default 3: consecutive same-direction steps needed to declare lock (range 1..15).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 count_in  input  WIDTH  observed up/down counter value.
REQ-006 sample_en  input  1  count_in is sampled in cycles where this is high.
REQ-007 dir  output  1  last detected direction: 1 = up, 0 = down.
REQ-008 step  output  1  one-cycle pulse when a legal +/-1 step is detected.
REQ-009 hold  output  1  one-cycle pulse when a sample equals the previous sample.
REQ-010 err  output  1  one-cycle pulse when a sample differs by other than 0 or +/-1 (mod 2^WIDTH).
REQ-011 locked  output  1  high while in a LOCKED state.
REQ-012 err_count  output  8  saturating count of err pulses since reset.

Function
REQ-013 All outputs are registered; a response appears on the first clk edge after the sampled cycle (latency 1).
REQ-014 When sample_en is low: no state change, and step/hold/err are 0 on the next cycle.
REQ-015 Delta = (count_in - prev) mod 2^WIDTH; +1 is an up step (includes 2^WIDTH-1 -> 0); 2^WIDTH-1 is a down step (includes 0 -> 2^WIDTH-1); 0 is hold; any other value is illegal.
REQ-016 States: INIT, SEEK, LOCK_UP, LOCK_DOWN; a 4-bit run counter tracks consecutive same-direction steps.
REQ-017 INIT: the first sample only loads prev, produces no pulse, and moves to SEEK with run = 0.
REQ-018 SEEK, legal step: assert step, set dir; run increments if same as dir, else run = 1; run reaching LOCK_CNT moves to LOCK_UP or LOCK_DOWN.
REQ-019 LOCK_x, same-direction step: assert step and stay; run saturates at LOCK_CNT.
REQ-020 LOCK_x, opposite step: assert step, flip dir, move to SEEK with run = 1; if LOCK_CNT = 1, move directly to the opposite LOCK state.
REQ-021 Hold in any non-INIT state: assert hold; state, run and dir are unchanged.
REQ-022 Illegal delta in any non-INIT state: assert err, move to SEEK with run = 0, leave dir unchanged, increment err_count (saturates at 255).
REQ-023 prev is updated with count_in on every sampled cycle, including hold and illegal samples.
REQ-024 step, hold and err are mutually exclusive in every cycle.

Reset
REQ-025 While rst is high: state = INIT, run = 0, prev = 0, dir = 1, and step = hold = err = locked = 0, err_count = 0.
REQ-026 rst asserted mid-sequence takes effect immediately; the first sample after release is treated as an INIT sample.

Structure
REQ-027 A shared package holds the state enumeration, the delta-class encoding (UP/DOWN/HOLD/ILLEGAL) and the default LOCK_CNT constant.
REQ-028 One sub-module, delta_classifier, is purely combinational: it takes prev and count_in and returns the delta class.
REQ-029 The top level holds the state machine, prev, run, err_count and the output registers.

Verification
REQ-030 Reset release, then samples 5,6,7,8 -> no pulse on the 5; step on each later sample; dir = 1; locked goes high one cycle after the 8 is sampled.
REQ-031 Samples 14,15,0,1 -> three step pulses with dir = 1 and no err (up wrap); then samples 1,0,15 -> step pulses, dir = 0, locked drops after the first down step.
REQ-032 In LOCK_UP, sample 9 then 9 -> hold pulse and locked stays 1; then sample 12 -> err pulse, locked = 0, err_count increments by 1.
REQ-033 sample_en toggles low for 3 cycles between samples 3 and 4 -> step pulses only after sampled cycles; no pulses in the gaps.
REQ-034 256 illegal jumps alternating between 0 and 8 -> err_count saturates at 255 and never wraps.
REQ-035 rst pulsed while in LOCK_DOWN -> all outputs are 0 during reset and dir = 1; the next sample produces no pulse.
